// File: rtl/frec_conmu_param.sv
// frec_conmu_param: button-driven switching-frequency generator.
// Two front-panel buttons step a level register (saturating or wrapping).
// The level selects the half period of a divided square wave. Divisor updates
// take effect only at a half-period boundary, so the output never glitches.
// The block also produces a free-running 1 kHz reference square wave.
//
// Optional feature: define FREC_AUTO_REPEAT_EN to add hold-to-repeat stepping.
// While a button is held, one extra step is produced every REPEAT_CYCLES cycles.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-high reset
//   aumentar      increase-level button (asynchronous)
//   disminuir     decrease-level button (asynchronous)
//   chip_select   button enable (synchronous)
//   clk_out       divided square wave, half period HALF_BASE*(N_LEVELS-nivel)
//   clk_1k        1 kHz square wave
//   nivel         current level
//   nivel_cambio  one-cycle pulse in the first cycle nivel shows a new value
module frec_conmu_param #(
  parameter int unsigned CLK_HZ        = 100_000_000,
  parameter int unsigned N_LEVELS      = 16,
  parameter int unsigned HALF_BASE     = 1000,
  parameter int unsigned RESET_LEVEL   = 0,
  parameter int unsigned WRAP          = 0,
  parameter int unsigned REPEAT_CYCLES = 25_000_000,
  localparam int unsigned LW = (N_LEVELS > 2) ? $clog2(N_LEVELS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          aumentar,
  input  logic          disminuir,
  input  logic          chip_select,
  output logic          clk_out,
  output logic          clk_1k,
  output logic [LW-1:0] nivel,
  output logic          nivel_cambio
);

  localparam int unsigned HMAX = HALF_BASE * N_LEVELS;
  localparam int unsigned CW   = (HMAX > 2) ? $clog2(HMAX) : 1;
  localparam int unsigned HW   = $clog2(HMAX + 1);
  localparam int unsigned K1   = CLK_HZ / 2000;
  localparam int unsigned KW   = (K1 > 2) ? $clog2(K1) : 1;

  // Reject parameter sets the datapath cannot represent.
  if (N_LEVELS < 2 || RESET_LEVEL >= N_LEVELS || HALF_BASE == 0 ||
      CLK_HZ < 2000 || REPEAT_CYCLES == 0) begin : g_bad_params
    $error("frec_conmu_param: invalid parameter set");
  end

  // Half period for a level, evaluated at full 32-bit width before narrowing.
  function automatic logic [HW-1:0] half_of(input logic [LW-1:0] l);
    return HW'(HALF_BASE * (N_LEVELS - 32'(l)));
  endfunction

  // Button synchronisers and history; bit 0 = aumentar, bit 1 = disminuir.
  logic [1:0] s1, s2, p;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      p  <= '0;
    end else begin
      s1 <= {disminuir, aumentar};
      s2 <= s1;
      p  <= s2;
    end
  end

  // Press edges; a press is ignored while the other button is held.
  logic [1:0] pulse;
  logic       up_step, dn_step;
  logic       inc, dec;

  assign pulse   = s2 & ~p;
  assign up_step = pulse[0] & chip_select & ~s2[1];
  assign dn_step = pulse[1] & chip_select & ~s2[0];

`ifdef FREC_AUTO_REPEAT_EN
  localparam int unsigned RW = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;

  logic [RW-1:0] rep_cnt;
  logic          hold_up, hold_dn, rep_fire;

  assign hold_up  = chip_select & s2[0] & ~s2[1];
  assign hold_dn  = chip_select & s2[1] & ~s2[0];
  assign rep_fire = (hold_up | hold_dn) & ~(up_step | dn_step) &
                    (rep_cnt == RW'(REPEAT_CYCLES - 1));

  // Hold-time counter; restarts on every edge step and on any loss of hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_cnt <= '0;
    end else if (up_step || dn_step || !(hold_up || hold_dn) || rep_fire) begin
      rep_cnt <= '0;
    end else begin
      rep_cnt <= rep_cnt + RW'(1);
    end
  end

  assign inc = up_step | (rep_fire & hold_up);
  assign dec = dn_step | (rep_fire & hold_dn);
`else
  assign inc = up_step;
  assign dec = dn_step;
`endif

  // Next level with saturate/wrap at both ends.
  logic [LW-1:0] nivel_nx;

  always_comb begin
    nivel_nx = nivel;
    if (inc) begin
      if (nivel == LW'(N_LEVELS - 1)) begin
        nivel_nx = (WRAP != 0) ? '0 : nivel;
      end else begin
        nivel_nx = nivel + LW'(1);
      end
    end else if (dec) begin
      if (nivel == '0) begin
        nivel_nx = (WRAP != 0) ? LW'(N_LEVELS - 1) : nivel;
      end else begin
        nivel_nx = nivel - LW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nivel        <= LW'(RESET_LEVEL);
      nivel_cambio <= 1'b0;
    end else begin
      nivel        <= nivel_nx;
      nivel_cambio <= (nivel_nx != nivel);
    end
  end

  // Divider: the active half period is reloaded only when the output toggles.
  logic [CW-1:0] cnt;
  logic [HW-1:0] h_act;
  logic          div_wrap;

  assign div_wrap = (HW'(cnt) == (h_act - HW'(1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      h_act   <= half_of(LW'(RESET_LEVEL));
      clk_out <= 1'b0;
    end else if (div_wrap) begin
      cnt     <= '0;
      h_act   <= half_of(nivel);
      clk_out <= ~clk_out;
    end else begin
      cnt     <= cnt + CW'(1);
    end
  end

  // 1 kHz reference, independent of the buttons.
  logic [KW-1:0] k_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_cnt  <= '0;
      clk_1k <= 1'b0;
    end else if (k_cnt == KW'(K1 - 1)) begin
      k_cnt  <= '0;
      clk_1k <= ~clk_1k;
    end else begin
      k_cnt  <= k_cnt + KW'(1);
    end
  end

endmodule
